// File: rtl/pb_event_decoder.sv
// Push-button event decoder: synchronizes, debounces and classifies PB_SW into press/release/long pulses.
// Optional auto-repeat while held long is enabled by defining PB_AUTOREPEAT_EN.
module pb_event_decoder #(
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int LONG_PRESS_CYCLES = 50000,
  parameter int REPEAT_CYCLES     = 10000,
  parameter int CNT_W             = 16,
  parameter int LED_W             = 8
) (
  input  logic             CLK,
  input  logic             DEVRST_N,
  input  logic             PB_SW,
  output logic             pb_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [LED_W-1:0] press_count,
  output logic [LED_W-1:0] LED
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef PB_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Reject configurations the shared counter cannot time.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (1 << CNT_W) ||
      LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES >= (1 << CNT_W) ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_param
    $error("pb_event_decoder: cycle parameter out of range for CNT_W");
  end

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             long_flag;

  // Two-flop synchronizer; idles high because the button is active-low.
  always_ff @(posedge CLK or negedge DEVRST_N) begin
    if (!DEVRST_N) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= PB_SW;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or negedge DEVRST_N) begin
    if (!DEVRST_N) begin
      state         <= IDLE;
      cnt           <= '0;
      long_flag     <= 1'b0;
      pb_level      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
      LED           <= '1;
    end else begin
      // NOTE: pulses default low here and are raised only by the transition that owns them,
      // so each lasts exactly one cycle; the later assignment in this block wins.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      LED           <= ~press_count;

      case (state)
        IDLE: begin
          if (!s2) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end
        end

        PRESS_WAIT: begin
          if (s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            pb_level    <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (s2) begin
            state     <= RELEASE_WAIT;
            cnt       <= CNT_W'(1);
            long_flag <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HELD;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LONG_HELD: begin
          if (s2) begin
            state     <= RELEASE_WAIT;
            cnt       <= CNT_W'(1);
            long_flag <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
          end else if (cnt == REP_LAST) begin
            cnt         <= '0;
            press_pulse <= 1'b1;
            press_count <= press_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          end else begin
            cnt <= '0;
          end
`endif
        end

        // pb_level stays high here: a release is not accepted until it has debounced.
        RELEASE_WAIT: begin
          if (!s2) begin
            state <= long_flag ? LONG_HELD : PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            pb_level      <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Directed self-checking bench for pb_event_decoder with D=4, LONG=20, REPEAT=8, LED_W=4.
// Expected pulse timings are offsets from edge 0, the first edge sampling the new PB_SW level.
module tb_pb_event_decoder;

  localparam int D    = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int LW   = 4;

  logic          CLK = 1'b0;
  logic          DEVRST_N;
  logic          PB_SW;
  logic          pb_level;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;
  logic [LW-1:0] press_count;
  logic [LW-1:0] LED;

  pb_event_decoder #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES    (REP),
    .CNT_W            (16),
    .LED_W            (LW)
  ) dut (
    .CLK          (CLK),
    .DEVRST_N     (DEVRST_N),
    .PB_SW        (PB_SW),
    .pb_level     (pb_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count),
    .LED          (LED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0     = 0;
  int n_press, n_rel, n_long, overlap;
  int first_rel, first_long;
  int press_q[$];
  int rep_exp[5] = '{5, 33, 41, 49, 57};
  logic [LW-1:0] led_at_press, cnt_at_press;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) overlap++;
    if (press_pulse) begin
      n_press++;
      press_q.push_back(cyc);
      if (n_press == 1) begin
        led_at_press = LED;
        cnt_at_press = press_count;
      end
    end
    if (release_pulse) begin
      n_rel++;
      if (first_rel < 0) first_rel = cyc;
    end
    if (long_pulse) begin
      n_long++;
      if (first_long < 0) first_long = cyc;
    end
  endtask

  task automatic drive(input logic v, input int n);
    PB_SW = v;
    e0 = cyc + 1;
    repeat (n) step();
  endtask

  task automatic clear_stats();
    n_press = 0;
    n_rel = 0;
    n_long = 0;
    first_rel = -1;
    first_long = -1;
    press_q.delete();
  endtask

  function automatic int first_press();
    return (press_q.size() > 0) ? press_q[0] : -1000;
  endfunction

  task automatic apply_reset();
    DEVRST_N = 1'b0;
    PB_SW = 1'b1;
    repeat (2) step();
    DEVRST_N = 1'b1;
    repeat (3) step();
    clear_stats();
  endtask

  initial begin
    overlap = 0;
    clear_stats();

    // Power-on reset with the button held down.
    DEVRST_N = 1'b0;
    PB_SW = 1'b0;
    repeat (3) step();
    check("rst_pb_level", pb_level, 0);
    check("rst_pulses", n_press + n_rel + n_long, 0);
    check("rst_press_count", press_count, 0);
    check("rst_led", LED, 4'b1111);
    DEVRST_N = 1'b1;
    e0 = cyc + 1;
    repeat (8) step();
    check("por_press_lat", first_press() - e0, 5);

    // Reset asserted mid-press takes effect without a clock and emits nothing.
    clear_stats();
    DEVRST_N = 1'b0;
    #1;
    check("async_rst_level", pb_level, 0);
    check("async_rst_count", press_count, 0);
    check("async_rst_led", LED, 4'b1111);
    repeat (2) step();
    check("midrst_pulses", n_press + n_rel + n_long, 0);
    DEVRST_N = 1'b1;
    e0 = cyc + 1;
    repeat (8) step();
    check("midrst_redetect_lat", first_press() - e0, 5);
    check("midrst_count", press_count, 1);
    drive(1'b1, 10);

    // Clean press, a short release glitch, then a real release.
    apply_reset();
    drive(1'b0, 12);
    check("clean_press_lat", first_press() - e0, 5);
    check("clean_n_press", n_press, 1);
    check("clean_count_at_pulse", cnt_at_press, 1);
    check("clean_led_lags", led_at_press, 4'b1111);
    check("clean_level", pb_level, 1);
    check("clean_count", press_count, 1);
    check("clean_led", LED, 4'b1110);
    drive(1'b1, 2);
    drive(1'b0, 6);
    check("glitch_no_release", n_rel, 0);
    check("glitch_level", pb_level, 1);
    drive(1'b1, 10);
    check("clean_rel_lat", first_rel - e0, 5);
    check("clean_n_rel", n_rel, 1);
    check("clean_rel_level", pb_level, 0);
    check("clean_no_long", n_long, 0);

    // Bouncing press: low 3, high 1, low 2, high 1, then steady low.
    apply_reset();
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 15);
    check("bounce_n_press", n_press, 1);
    check("bounce_press_lat", first_press() - e0, 5);
    check("bounce_count", press_count, 1);
    drive(1'b1, 10);
    check("bounce_n_rel", n_rel, 1);

    // Long press held 40 cycles.
    apply_reset();
    drive(1'b0, 40);
    check("long_press_lat", first_press() - e0, 5);
    check("long_pulse_lat", first_long - e0, 25);
    check("long_n_long", n_long, 1);
`ifdef PB_AUTOREPEAT_EN
    check("long_n_press", n_press, 2);
`else
    check("long_n_press", n_press, 1);
`endif
    check("long_level", pb_level, 1);
    drive(1'b1, 10);
    check("long_n_rel", n_rel, 1);
    check("long_rel_lat", first_rel - e0, 5);

    // Sixteen presses wrap the 4-bit counter.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8);
      drive(1'b1, 8);
      if (i == 14) begin
        check("wrap_count_15", press_count, 15);
        check("wrap_led_15", LED, 4'b0000);
      end
    end
    check("wrap_n_press", n_press, 16);
    check("wrap_count_0", press_count, 0);
    check("wrap_led_0", LED, 4'b1111);

    // Hold 60 cycles: auto-repeat pulses only when the feature is built in.
    apply_reset();
    drive(1'b0, 60);
`ifdef PB_AUTOREPEAT_EN
    check("rep_n_press", n_press, 5);
    for (int k = 0; k < 5 && k < press_q.size(); k++)
      check($sformatf("rep_lat_%0d", k), press_q[k] - e0, rep_exp[k]);
    check("rep_count", press_count, 5);
`else
    check("rep_n_press", n_press, 1);
    check("rep_first_lat", first_press() - e0, rep_exp[0]);
    check("rep_count", press_count, 1);
`endif
    drive(1'b1, 10);
    check("rep_n_rel", n_rel, 1);

    check("pulse_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_event_decoder.md
Name: pb_event_decoder

Overview:
- Fabric-side receiver for the board push-button line PB_SW. Raw active-low pushbutton in, clean events out.
- Synchronizes and debounces the button, then classifies each press as short or long.
- Emits single-cycle press, release and long-press pulses, and keeps a press counter that is driven to the active-low board LEDs.
- Sits inside Top between the PB_SW pad and the LED output logic.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable synchronized samples needed to accept a level change; must be >= 2
LONG_PRESS_CYCLES, 50000, cycles held in PRESSED, after press acceptance, before a long press is declared
REPEAT_CYCLES, 10000, auto-repeat interval in LONG_HELD; used only with the optional feature
CNT_W, 16, width of the shared timing counter; 2^CNT_W must exceed every cycle parameter
LED_W, 8, width of press_count and LED

Ports:
CLK  input  1  fabric clock, all logic on rising edge
DEVRST_N  input  1  asynchronous active-low reset
PB_SW  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLK
pb_level  output  1  debounced level, 1 = pressed (states PRESSED and LONG_HELD)
press_pulse  output  1  one-cycle pulse on each accepted press (and on each auto-repeat)
release_pulse  output  1  one-cycle pulse on each accepted release
long_pulse  output  1  one-cycle pulse when a press becomes long
press_count  output  LED_W  count of press_pulse events, wraps modulo 2^LED_W
LED  output  LED_W  registered ~press_count (board LEDs are active-low)

Behaviour:
- Reset (DEVRST_N=0, asynchronous):
  - Both synchronizer flops = 1; state = IDLE; cnt = 0; all pulses = 0.
  - press_count = 0; LED = all ones; pb_level = 0.
  - Reset mid-press aborts all activity with no pulses.
  - If the button is still held after reset release, it is re-detected as a new press through the normal PRESS_WAIT path.
- Synchronizer: s1 <= PB_SW; s2 <= s1. The FSM uses s2 only.
- Timing reference: edge 0 is the first rising edge that samples PB_SW at its new level.
- IDLE: if s2=0, go to PRESS_WAIT with cnt=1 (edge 2).
- PRESS_WAIT:
  - s2=1: return to IDLE, cnt=0.
  - s2=0 and cnt<D-1: cnt+1.
  - s2=0 and cnt==D-1: go to PRESSED, cnt=0, press_pulse=1.
  - Result: press_pulse is high in the cycle after edge D+1.
- PRESSED:
  - s2=1: go to RELEASE_WAIT, cnt=1, long flag=0.
  - s2=0 and cnt<LONG-1: cnt+1.
  - s2=0 and cnt==LONG-1: go to LONG_HELD, cnt=0, long_pulse=1 (cycle after edge D+1+LONG from the press).
- LONG_HELD: s2=1 goes to RELEASE_WAIT with cnt=1 and long flag=1. Otherwise hold (see the optional feature).
- RELEASE_WAIT:
  - s2=0: return to LONG_HELD if long flag=1, else to PRESSED; cnt=0 (long timing restarts).
  - s2=1 and cnt==D-1: go to IDLE, release_pulse=1, exactly D+1 edges after the release edge 0.
- Pulse rules:
  - All pulses are registered and last exactly 1 cycle.
  - press_pulse, release_pulse and long_pulse never coincide, because each comes from a different transition.
- press_count and LED:
  - press_count increments in the same cycle press_pulse is high; 2^LED_W-1 wraps to 0.
  - LED updates one cycle after press_count.
- Glitches shorter than D synchronized cycles produce no pulse and no change to pb_level.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD, cnt counts held cycles.
  - When cnt==REPEAT-1 and s2=0: press_pulse=1, press_count+1, cnt=0.
  - First repeat pulse is REPEAT edges after long_pulse; further repeats follow every REPEAT cycles.
- Undefined: LONG_HELD emits nothing; REPEAT_CYCLES is ignored; cnt is held at 0 in LONG_HELD.

Test Plan:
- All scenarios use D=4, LONG=20, REPEAT=8, LED_W=4.
- Reset: DEVRST_N=0 with PB_SW=0 -> pb_level=0, pulses=0, press_count=0, LED=4'b1111; release reset with button held -> press_pulse 5 edges later.
- Clean press: PB_SW=0 from edge 0, held 12 cycles, then 1 -> press_pulse in the cycle after edge 5, press_count=1, LED=4'b1110, pb_level=1; release_pulse 5 edges after the release edge; no long_pulse.
- Bounce: PB_SW low 3 cycles, high 1, low 2, high 1, then low steady -> exactly one press_pulse, 5 edges after the start of the final steady low; press_count=1.
- Long press: PB_SW=0 held 40 cycles -> press_pulse after edge 5, long_pulse after edge 25, exactly one press_pulse without the macro; release gives one release_pulse.
- Wrap: 16 clean presses -> press_count goes 15 -> 0 and LED=4'b1111 after the 16th press.
- Auto-repeat (PB_AUTOREPEAT_EN defined): hold 60 cycles -> press_pulse after edges 5, 33, 41, 49, 57; press_count=5. Same stimulus without the macro -> press_count=1.
